// File: rtl/cmp_minmax_scheduler_if.sv
// cmp_minmax_scheduler_if: sample stream in, frame min/max/count results out.
interface cmp_minmax_scheduler_if #(parameter int N = 4, parameter int CNT_W = 8);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             in_last;
    logic             done;
    logic [N-1:0]     res_max;
    logic [N-1:0]     res_min;
    logic [CNT_W-1:0] res_count;
    modport master (output in_valid, in_data, in_last,
                    input  in_ready, done, res_max, res_min, res_count);
    modport slave  (input  in_valid, in_data, in_last,
                    output in_ready, done, res_max, res_min, res_count);
endinterface

// File: rtl/cmp_minmax_scheduler.sv
// cmp_minmax_scheduler: frame min/max finder sharing one magnitude comparator
// between the running-max and running-min updates.
module cmp_mag #(parameter int N = 4) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt,
    output logic         gt,
    output logic         eq
);
    assign lt = a < b;
    assign gt = a > b;
    assign eq = a == b;
endmodule

module cmp_minmax_scheduler #(parameter int N = 4, parameter int CNT_W = 8) (
    input  logic                  clk,
    input  logic                  rst,
    cmp_minmax_scheduler_if.slave bus
);
    typedef enum logic [1:0] {ACCEPT, CMP_MAX, CMP_MIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     sample_q, sample_d;
    logic             last_q, last_d;
    logic             first_q, first_d;
    logic [N-1:0]     work_max_q, work_max_d;
    logic [N-1:0]     work_min_q, work_min_d;
    logic [CNT_W-1:0] work_cnt_q, work_cnt_d;
    logic [N-1:0]     res_max_q, res_max_d;
    logic [N-1:0]     res_min_q, res_min_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;
    logic             done_q, done_d;
    logic             cmp_lt, cmp_gt, cmp_eq;
    logic             xfer;

    // Single shared comparator: B selects the working max only in CMP_MAX.
    cmp_mag #(.N(N)) u_cmp (
        .a  (sample_q),
        .b  (state_q == CMP_MAX ? work_max_q : work_min_q),
        .lt (cmp_lt),
        .gt (cmp_gt),
        .eq (cmp_eq)
    );

    assign bus.in_ready  = state_q == ACCEPT;
    assign bus.done      = done_q;
    assign bus.res_max   = res_max_q;
    assign bus.res_min   = res_min_q;
    assign bus.res_count = res_count_q;
    assign xfer          = bus.in_valid & bus.in_ready;

    always_comb begin
        state_d     = state_q;
        sample_d    = sample_q;
        last_d      = last_q;
        first_d     = first_q;
        work_max_d  = work_max_q;
        work_min_d  = work_min_q;
        work_cnt_d  = work_cnt_q;
        res_max_d   = res_max_q;
        res_min_d   = res_min_q;
        res_count_d = res_count_q;
        done_d      = 1'b0;
        case (state_q)
            ACCEPT: if (xfer) begin
                if (first_q) begin
                    work_max_d = bus.in_data;
                    work_min_d = bus.in_data;
                    work_cnt_d = CNT_W'(1);
                    first_d    = 1'b0;
                    state_d    = bus.in_last ? DONE : ACCEPT;
                end else begin
                    sample_d   = bus.in_data;
                    last_d     = bus.in_last;
                    work_cnt_d = &work_cnt_q ? work_cnt_q : work_cnt_q + 1'b1;
                    state_d    = CMP_MAX;
                end
            end
            CMP_MAX: begin
                work_max_d = (cmp_gt & ~cmp_eq) ? sample_q : work_max_q;
                state_d    = CMP_MIN;
            end
            CMP_MIN: begin
                work_min_d = (cmp_lt & ~cmp_eq) ? sample_q : work_min_q;
                state_d    = last_q ? DONE : ACCEPT;
            end
            default: begin
                res_max_d   = work_max_q;
                res_min_d   = work_min_q;
                res_count_d = work_cnt_q;
                done_d      = 1'b1;
                first_d     = 1'b1;
                state_d     = ACCEPT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCEPT;
            sample_q    <= '0;
            last_q      <= 1'b0;
            first_q     <= 1'b1;
            work_max_q  <= '0;
            work_min_q  <= '0;
            work_cnt_q  <= '0;
            res_max_q   <= '0;
            res_min_q   <= '0;
            res_count_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sample_q    <= sample_d;
            last_q      <= last_d;
            first_q     <= first_d;
            work_max_q  <= work_max_d;
            work_min_q  <= work_min_d;
            work_cnt_q  <= work_cnt_d;
            res_max_q   <= res_max_d;
            res_min_q   <= res_min_d;
            res_count_q <= res_count_d;
            done_q      <= done_d;
        end
    end
endmodule

// File: tb/tb_cmp_minmax_scheduler.sv
// tb_cmp_minmax_scheduler: directed frames with hand-computed min/max/count,
// handshake pattern, latency, mid-frame reset and gapped-valid checks.
module tb_cmp_minmax_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    logic [3:0] smp [8];
    int   nsmp;
    logic [7:0] rdy_pat = 8'b10010011;

    cmp_minmax_scheduler_if #(.N(4), .CNT_W(8)) bus ();
    cmp_minmax_scheduler #(.N(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Drives smp[0..nsmp-1]; on non-transfer cycles it presents extreme garbage.
    task automatic run_frame(input bit gap, input bit log_rdy, input bit fin);
        int  i = 0;
        int  cyc = 0;
        logic xfer;
        while (i < nsmp && cyc < 200) begin
            @(negedge clk);
            bus.in_valid = gap ? (cyc % 2 == 0) : 1'b1;
            if (bus.in_valid && bus.in_ready) begin
                bus.in_data = smp[i];
                bus.in_last = fin && (i == nsmp - 1);
            end else begin
                bus.in_data = cyc[0] ? 4'hF : 4'h0;
                bus.in_last = 1'b1;
            end
            if (log_rdy && cyc < 8) check($sformatf("ready_c%0d", cyc), 32'(bus.in_ready), 32'(rdy_pat[cyc]));
            xfer = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (xfer) i++;
            cyc++;
        end
        if (i < nsmp) check("frame_timeout", i, nsmp);
    endtask

    task automatic wait_done(input int exp_lat, input bit eq_chk);
        int lat = 0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.done && lat < 10) begin
            if (eq_chk && lat < 2) begin
                check($sformatf("cmp_eq_l%0d", lat), 32'(dut.cmp_eq), 1);
                check($sformatf("wmax_l%0d", lat), 32'(dut.work_max_q), 6);
                check($sformatf("wmin_l%0d", lat), 32'(dut.work_min_q), 6);
            end
            @(negedge clk);
            lat++;
        end
        check("done_latency", lat, exp_lat);
        check("done_seen", 32'(bus.done), 1);
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 0);
    endtask

    task automatic check_res(input string tag, input int mx, input int mn, input int cnt);
        check({tag, "_max"}, 32'(bus.res_max), mx);
        check({tag, "_min"}, 32'(bus.res_min), mn);
        check({tag, "_cnt"}, 32'(bus.res_count), cnt);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        #1;
        check("rst_ready", 32'(bus.in_ready), 1);
        check("rst_done", 32'(bus.done), 0);
        check_res("rst", 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        smp = '{4'd5, 4'd9, 4'd2, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0}; nsmp = 4;
        run_frame(1'b0, 1'b1, 1'b1);
        wait_done(3, 1'b0);
        check_res("f5927", 9, 2, 4);

        smp[0] = 4'hA; nsmp = 1;
        run_frame(1'b0, 1'b0, 1'b1);
        wait_done(1, 1'b0);
        check_res("single", 10, 10, 1);

        smp = '{4'd6, 4'd6, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}; nsmp = 3;
        run_frame(1'b0, 1'b0, 1'b1);
        wait_done(3, 1'b1);
        check_res("equal", 6, 6, 3);

        smp = '{4'd15, 4'd0, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}; nsmp = 4;
        run_frame(1'b0, 1'b0, 1'b1);
        wait_done(3, 1'b0);
        check_res("bound", 15, 0, 4);

        smp = '{4'd3, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}; nsmp = 2;
        run_frame(1'b0, 1'b0, 1'b1);
        #1;
        check_res("held", 15, 0, 4);
        wait_done(3, 1'b0);
        check_res("f34", 4, 3, 2);

        smp = '{4'd8, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}; nsmp = 2;
        run_frame(1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_res("midrst", 0, 0, 0);
        check("midrst_ready", 32'(bus.in_ready), 1);
        check("midrst_done", 32'(bus.done), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("midrst_nodone%0d", k), 32'(bus.done), 0);
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("post_rst_nodone%0d", k), 32'(bus.done), 0);
        end

        smp = '{4'd2, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}; nsmp = 2;
        run_frame(1'b0, 1'b0, 1'b1);
        wait_done(3, 1'b0);
        check_res("f23", 3, 2, 2);

        smp = '{4'd5, 4'd9, 4'd2, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0}; nsmp = 4;
        run_frame(1'b1, 1'b0, 1'b1);
        wait_done(3, 1'b0);
        check_res("gapped", 9, 2, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
